regfile_wb_queue: RTL and testbench
===================================

# regfile_wb_queue

Write-back initiator for the integer register file. It accepts results from the ALU and the load/store unit over valid/ready handshakes and buffers them in a small in-order queue. It drains the queue one entry per cycle onto the register file's single write port (reg_write / write_index / write_data). It also services decode's two read ports, forwarding queued-but-unwritten values so decode never sees a stale register.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_valid / alu_ready  in / out  1  ALU result handshake
- alu_rd  in  5  ALU destination index
- alu_data  in  32  ALU result
- lsu_valid / lsu_ready  in / out  1  load result handshake
- lsu_rd  in  5  load destination index
- lsu_data  in  32  load result
- wb_stall  in  1  hold the queue head; no write this cycle
- reg_write  out  1  register file write enable
- write_index  out  5  register file write index
- write_data  out  32  register file write data
- dec_index1, dec_index2  in  5  decode read indices (also drive register file read_index1/2)
- rf_data1, rf_data2  in  32  register file read_data1/2
- dec_data1, dec_data2  out  32  forwarded read data to decode
- hazard1, hazard2  out  1  index matches a pending queue entry
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular queue with head pointer, tail pointer and count. All state is cleared by rst.
- Pop: the head entry drives reg_write=1, write_index and write_data combinationally whenever count>0 and wb_stall=0. The head is removed at that clock edge.
- When count=0 or wb_stall=1, reg_write=0; write_index and write_data hold the head values (zero when empty).
- free = DEPTH − count + pop. Only requests with rd≠0 consume space.
- A request with rd=0 is accepted (ready=1) and dropped; it is never enqueued.
- lsu_ready = (lsu_rd==0) || free≥1.
- alu_ready = (alu_rd==0) || free ≥ 1 + (lsu_valid && lsu_rd≠0).
- Both sources may enqueue in the same cycle. The LSU entry is enqueued first (older), the ALU entry second.
- Tail and head wrap modulo DEPTH. Simultaneous push and pop with count=DEPTH is legal: pop frees the slot.
- hazard1 = (dec_index1≠0) and some valid entry has rd==dec_index1. hazard2 is defined the same way for index 2.
- x0 never hazards; dec_dataN for x0 is always 0.

## Timing
- Reset values: reg_write=0, write_index=0, write_data=0, count=0, hazard1/2=0, all queue entries invalid.
- While rst=1, alu_ready=0 and lsu_ready=0.
- rst asserted mid-operation discards all pending entries. reg_write=0 in the cycle following the reset edge.
- Latency with an empty queue and no stall: a request accepted at edge E appears on the write port during cycle E+1 and is written at edge E+1.
- Under a same-cycle LSU+ALU enqueue, the LSU entry is written first and the ALU entry one cycle later.
- Handshake outputs (ready, hazard, dec_data) are combinational from current state and inputs. There is no combinational path from alu_valid to lsu_ready.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - dec_dataN takes the data of the youngest valid entry matching dec_indexN.
  - Otherwise dec_dataN = rf_dataN.
  - The head entry being written this cycle still forwards.
- REGFILE_WB_BYPASS_EN undefined:
  - dec_dataN = rf_dataN always, with x0 forced to 0.
  - Decode must stall on hazardN.
  - Forwarding muxes are not built.

## Test plan
- Empty queue, ALU writes x5=0x1234 at edge 1 → cycle 2: reg_write=1, write_index=5, write_data=0x1234; cycle 3: reg_write=0, count=0.
- Same cycle, LSU x3=0xA and ALU x4=0xB → writes x3 then x4 on consecutive cycles; count peaks at 2.
- wb_stall=1 with 4 ALU pushes (DEPTH=4) → count=4, alu_ready=0, reg_write=0. Release stall with a push held → pop and push in the same cycle, count stays 4, entries drain in order.
- Queue holds x7=0x1 then x7=0x2 (unwritten), dec_index1=7 → hazard1=1. With the macro, dec_data1=0x2; without it, dec_data1=rf_data1.
- ALU rd=0, data 0xFFFF → alu_ready=1, count unchanged, no reg_write. dec_index2=0 → dec_data2=0, hazard2=0.
- 3 entries pending, then rst=1 for one cycle → count=0, reg_write=0, hazard1/2=0. A fresh push is written two cycles after reset deasserts.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register file write port, with decode hazard detection.
// Define REGFILE_WB_BYPASS_EN to build forwarding of queued data onto dec_data1/2.
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [31:0]              lsu_data,
  input  logic                     wb_stall,
  output logic                     reg_write,
  output logic [4:0]               write_index,
  output logic [31:0]              write_data,
  input  logic [4:0]               dec_index1,
  input  logic [4:0]               dec_index2,
  input  logic [31:0]              rf_data1,
  input  logic [31:0]              rf_data2,
  output logic [31:0]              dec_data1,
  output logic [31:0]              dec_data2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          pop;
  logic [CW-1:0] free;
  logic          lsu_need;
  logic          lsu_push;
  logic          alu_push;
  logic [AW-1:0] alu_slot;
  logic [AW-1:0] scan_slot;

  assign count = count_q;

  // Reset gates the pop so an entry caught by reset is discarded, not written.
  assign pop      = !rst && (count_q != '0) && !wb_stall;
  assign free     = CW'(DEPTH) - count_q + CW'(pop);
  assign lsu_need = lsu_valid && (lsu_rd != 5'd0);

  // alu_ready looks at lsu_valid, never the reverse, so no loop through alu_valid.
  assign lsu_ready = !rst && ((lsu_rd == 5'd0) || (free != '0));
  assign alu_ready = !rst && ((alu_rd == 5'd0) || (free >= CW'(1) + CW'(lsu_need)));

  assign lsu_push = lsu_need && lsu_ready;
  assign alu_push = alu_valid && (alu_rd != 5'd0) && alu_ready;
  // LSU takes the tail slot first; ALU lands behind it when both push.
  assign alu_slot = tail + AW'(lsu_push);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + AW'(pop);
      tail    <= tail + AW'(lsu_push) + AW'(alu_push);
      count_q <= count_q + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // NOTE: queue storage is not reset; occupancy (count_q) alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (lsu_push) begin
      rd_mem[tail]   <= lsu_rd;
      data_mem[tail] <= lsu_data;
    end
    if (alu_push) begin
      rd_mem[alu_slot]   <= alu_rd;
      data_mem[alu_slot] <= alu_data;
    end
  end

  assign reg_write   = pop;
  assign write_index = (count_q != '0) ? rd_mem[head]   : 5'd0;
  assign write_data  = (count_q != '0) ? data_mem[head] : 32'd0;

`ifdef REGFILE_WB_BYPASS_EN
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  // Walk oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    hazard1   = 1'b0;
    hazard2   = 1'b0;
    scan_slot = head;
`ifdef REGFILE_WB_BYPASS_EN
    fwd_data1 = rf_data1;
    fwd_data2 = rf_data2;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_slot = head + AW'(k);
      if (CW'(k) < count_q) begin
        if (rd_mem[scan_slot] == dec_index1) begin
          hazard1 = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
          fwd_data1 = data_mem[scan_slot];
`endif
        end
        if (rd_mem[scan_slot] == dec_index2) begin
          hazard2 = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
          fwd_data2 = data_mem[scan_slot];
`endif
        end
      end
    end
    if (dec_index1 == 5'd0) hazard1 = 1'b0;
    if (dec_index2 == 5'd0) hazard2 = 1'b0;
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign dec_data1 = (dec_index1 == 5'd0) ? 32'd0 : fwd_data1;
  assign dec_data2 = (dec_index2 == 5'd0) ? 32'd0 : fwd_data2;
`else
  assign dec_data1 = (dec_index1 == 5'd0) ? 32'd0 : rf_data1;
  assign dec_data2 = (dec_index2 == 5'd0) ? 32'd0 : rf_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized and directed bench for regfile_wb_queue against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        wb_stall;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic [4:0]  dec_index1, dec_index2;
  logic [31:0] rf_data1, rf_data2, dec_data1, dec_data2;
  logic        hazard1, hazard2;
  logic [$clog2(DEPTH):0] count;

  entry_t model_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_stall(wb_stall), .reg_write(reg_write), .write_index(write_index), .write_data(write_data),
    .dec_index1(dec_index1), .dec_index2(dec_index2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .dec_data1(dec_data1), .dec_data2(dec_data2), .hazard1(hazard1), .hazard2(hazard2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decode view of one register: hazard if any pending entry targets it; forwarded value is the youngest.
  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic [31:0] rf,
                                             output logic hz);
    logic [31:0] d;
    hz = 1'b0;
    d  = (idx == 5'd0) ? 32'd0 : rf;
    foreach (model_q[i]) begin
      if (idx != 5'd0 && model_q[i].rd == idx) begin
        hz = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
        d = model_q[i].data;
`endif
      end
    end
    return d;
  endfunction

  task automatic idle();
    rst       = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    wb_stall  = 1'b0;
  endtask

  // One clock cycle: compare all outputs with the model, then advance the model at the edge.
  task automatic step();
    int          sz;
    int          free;
    logic        pop, exp_lr, exp_ar, hz1, hz2;
    logic [31:0] dd1, dd2;
    entry_t      e;
    #1;
    sz     = model_q.size();
    pop    = !rst && sz > 0 && !wb_stall;
    free   = DEPTH - sz + int'(pop);
    exp_lr = !rst && (lsu_rd == 5'd0 || free >= 1);
    exp_ar = !rst && (alu_rd == 5'd0 || free >= 1 + int'(lsu_valid && lsu_rd != 5'd0));
    dd1    = model_read(dec_index1, rf_data1, hz1);
    dd2    = model_read(dec_index2, rf_data2, hz2);
    check("count", 32'(count), 32'(sz));
    check("reg_write", 32'(reg_write), 32'(pop));
    check("write_index", 32'(write_index), sz > 0 ? 32'(model_q[0].rd) : 32'd0);
    check("write_data", write_data, sz > 0 ? model_q[0].data : 32'd0);
    check("lsu_ready", 32'(lsu_ready), 32'(exp_lr));
    check("alu_ready", 32'(alu_ready), 32'(exp_ar));
    check("hazard1", 32'(hazard1), 32'(hz1));
    check("hazard2", 32'(hazard2), 32'(hz2));
    check("dec_data1", dec_data1, dd1);
    check("dec_data2", dec_data2, dd2);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (lsu_valid && exp_lr && lsu_rd != 5'd0) begin
        e.rd = lsu_rd; e.data = lsu_data;
        model_q.push_back(e);
      end
      if (alu_valid && exp_ar && alu_rd != 5'd0) begin
        e.rd = alu_rd; e.data = alu_data;
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    alu_rd = 5'd0; alu_data = 32'd0; lsu_rd = 5'd0; lsu_data = 32'd0;
    dec_index1 = 5'd0; dec_index2 = 5'd0;
    rf_data1 = $urandom; rf_data2 = $urandom;
    @(posedge clk);
    @(negedge clk);

    // Reset state, still in reset
    #1;
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    step();
    rst = 1'b0;

    // Single ALU write, latency of one cycle
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    idle(); #1;
    check("tp1_reg_write", 32'(reg_write), 32'd1);
    check("tp1_write_index", 32'(write_index), 32'd5);
    check("tp1_write_data", write_data, 32'h1234);
    step();
    #1;
    check("tp1_done_write", 32'(reg_write), 32'd0);
    check("tp1_done_count", 32'(count), 32'd0);
    step();

    // Same-cycle LSU + ALU: LSU first
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hA;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hB;
    step();
    idle(); #1;
    check("tp2_count_peak", 32'(count), 32'd2);
    check("tp2_first_index", 32'(write_index), 32'd3);
    step();
    #1;
    check("tp2_second_index", 32'(write_index), 32'd4);
    check("tp2_second_data", write_data, 32'hB);
    step();

    // Fill under stall, then push and pop together at full
    wb_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(32'h100 + i);
      step();
    end
    alu_rd = 5'd20; alu_data = 32'h200;
    #1;
    check("tp3_full_count", 32'(count), 32'd4);
    check("tp3_full_ready", 32'(alu_ready), 32'd0);
    check("tp3_full_nowrite", 32'(reg_write), 32'd0);
    step();
    wb_stall = 1'b0;
    #1;
    check("tp3_release_ready", 32'(alu_ready), 32'd1);
    check("tp3_release_head", 32'(write_index), 32'd10);
    step();
    alu_valid = 1'b0;
    #1;
    check("tp3_count_held", 32'(count), 32'd4);
    for (int i = 0; i < DEPTH; i++) step();
    #1;
    check("tp3_drained", 32'(count), 32'd0);

    // Two pending writes to x7: hazard and youngest-value forwarding
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
    step();
    alu_data = 32'h2;
    step();
    alu_valid = 1'b0; dec_index1 = 5'd7; rf_data1 = 32'hDEAD_BEEF;
    #1;
    check("tp4_hazard1", 32'(hazard1), 32'd1);
`ifdef REGFILE_WB_BYPASS_EN
    check("tp4_dec_data1", dec_data1, 32'h2);
`else
    check("tp4_dec_data1", dec_data1, 32'hDEAD_BEEF);
`endif
    step();
    wb_stall = 1'b0;
    step();
    step();

    // rd=0 request is accepted and dropped; x0 reads zero
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    dec_index2 = 5'd0; rf_data2 = 32'h5555_5555;
    #1;
    check("tp5_alu_ready", 32'(alu_ready), 32'd1);
    check("tp5_dec_data2", dec_data2, 32'd0);
    check("tp5_hazard2", 32'(hazard2), 32'd0);
    step();
    idle(); #1;
    check("tp5_count", 32'(count), 32'd0);
    check("tp5_nowrite", 32'(reg_write), 32'd0);
    step();

    // Reset mid-operation discards pending entries
    wb_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'(i);
      step();
    end
    alu_valid = 1'b0; rst = 1'b1;
    step();
    idle(); dec_index1 = 5'd1; dec_index2 = 5'd2;
    #1;
    check("tp6_count", 32'(count), 32'd0);
    check("tp6_reg_write", 32'(reg_write), 32'd0);
    check("tp6_hazard1", 32'(hazard1), 32'd0);
    check("tp6_hazard2", 32'(hazard2), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    step();
    idle(); #1;
    check("tp6_fresh_write", 32'(reg_write), 32'd1);
    check("tp6_fresh_index", 32'(write_index), 32'd9);
    step();

    // Randomized traffic with small index range so hazards and rd=0 are frequent
    for (int n = 0; n < 500; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      alu_valid  = $urandom_range(0, 1) == 1;
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      lsu_valid  = $urandom_range(0, 1) == 1;
      lsu_rd     = 5'($urandom_range(0, 7));
      lsu_data   = $urandom;
      wb_stall   = ($urandom_range(0, 3) == 0);
      dec_index1 = 5'($urandom_range(0, 7));
      dec_index2 = 5'($urandom_range(0, 7));
      rf_data1   = $urandom;
      rf_data2   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
